// File: rtl/a2d_pkg.sv
// Shared definitions for the round-robin A2D sampler and its SPI master.
// Holds the frame geometry, the state encodings of both FSMs and small
// helpers that pick the next channel and build the SPI command word.
package a2d_pkg;

    localparam int FRAME_BITS    = 16;
    localparam int CMD_CHNNL_LSB = 11;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_FRAME = 2'd1,
        SEQ_GAP   = 2'd2
    } seq_state_t;

    typedef enum logic [2:0] {
        SPI_IDLE  = 3'd0,
        SPI_FRONT = 3'd1,
        SPI_SHIFT = 3'd2,
        SPI_BACK  = 3'd3,
        SPI_DONE  = 3'd4
    } spi_state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] first_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Conversion command: channel number in bits [13:11], all else zero.
    function automatic logic [FRAME_BITS-1:0] build_cmd(input logic [2:0] ch);
        return FRAME_BITS'(ch) << CMD_CHNNL_LSB;
    endfunction

endpackage

// File: rtl/spi_mstr_gen.sv
// 16-bit SPI master (mode 3 style: SCLK idles high, MOSI changes on fall,
// MISO sampled on rise). One frame per wrt pulse accepted in idle.
// Ports: clk/rst (sync, active high), wrt (start frame), cmd (word to send),
// done (1-clk pulse, rd_data valid), rd_data (received word),
// SS_n/SCLK/MOSI (SPI outputs, all registered), MISO (SPI input).
module spi_mstr_gen
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrt,
    input  logic [FRAME_BITS-1:0] cmd,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rd_data,
    output logic                  SS_n,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int HALF = SCLK_DIV / 2;
    localparam int CW   = $clog2(HALF) + 1;
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

    spi_state_t              state_r;
    logic [CW-1:0]           cnt_r;
    logic [3:0]              bit_r;
    logic [FRAME_BITS-2:0]   tx_r;      // bits still to send after the one on MOSI
    logic [FRAME_BITS-1:0]   rx_r;
    logic                    ss_n_r;
    logic                    sclk_r;
    logic                    mosi_r;
    logic                    done_r;

    assign done    = done_r;
    assign rd_data = rx_r;
    assign SS_n    = ss_n_r;
    assign SCLK    = sclk_r;
    assign MOSI    = mosi_r;

    // Frame FSM: half-period counter drives SCLK edges, shift registers move data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SPI_IDLE;
            cnt_r   <= '0;
            bit_r   <= 4'd0;
            tx_r    <= '0;
            rx_r    <= '0;
            ss_n_r  <= 1'b1;
            sclk_r  <= 1'b1;
            mosi_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                SPI_IDLE: begin
                    if (wrt) begin
                        ss_n_r  <= 1'b0;
                        mosi_r  <= cmd[FRAME_BITS-1];
                        tx_r    <= cmd[FRAME_BITS-2:0];
                        cnt_r   <= '0;
                        state_r <= SPI_FRONT;
                    end
                end
                SPI_FRONT: begin
                    if (cnt_r == HALF_END) begin
                        cnt_r   <= '0;
                        sclk_r  <= 1'b0;
                        bit_r   <= 4'd0;
                        state_r <= SPI_SHIFT;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                SPI_SHIFT: begin
                    if (cnt_r == HALF_END) begin
                        cnt_r <= '0;
                        if (!sclk_r) begin
                            sclk_r <= 1'b1;
                            rx_r   <= {rx_r[FRAME_BITS-2:0], MISO};
                        end else if (bit_r == LAST_BIT) begin
                            // last high phase runs on into BACK without a fall
                            state_r <= SPI_BACK;
                        end else begin
                            sclk_r <= 1'b0;
                            bit_r  <= bit_r + 4'd1;
                            mosi_r <= tx_r[FRAME_BITS-2];
                            tx_r   <= {tx_r[FRAME_BITS-3:0], 1'b0};
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                SPI_BACK: begin
                    if (cnt_r == HALF_END) begin
                        cnt_r   <= '0;
                        ss_n_r  <= 1'b1;
                        mosi_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= SPI_DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                SPI_DONE: begin
                    state_r <= SPI_IDLE;
                end
                default: begin
                    state_r <= SPI_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/a2d_rr_sampler.sv
// Round-robin A2D sampler: one strt_cnv sweeps all enabled channels in
// ascending order, one SPI frame each, and keeps the latest result per channel.
// Ports: clk/rst (sync, active high); strt_cnv + chnnl_mask start a sweep;
// rd_chnnl/rd_res read the result buffer (combinational); res/res_chnnl/
// res_vld report each result; cnv_cmplt marks sweep end; busy while sweeping;
// a2d_SS_n/SCLK/MOSI/MISO are the SPI pins.
module a2d_rr_sampler
    import a2d_pkg::*;
#(
    parameter int NUM_CHNNL = 8,
    parameter int RES_W     = 12,
    parameter int SCLK_DIV  = 32,
    parameter int INVERT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 strt_cnv,
    input  logic [NUM_CHNNL-1:0] chnnl_mask,
    input  logic [2:0]           rd_chnnl,
    output logic [RES_W-1:0]     rd_res,
    output logic [RES_W-1:0]     res,
    output logic [2:0]           res_chnnl,
    output logic                 res_vld,
    output logic                 cnv_cmplt,
    output logic                 busy,
    output logic                 a2d_SS_n,
    output logic                 SCLK,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int HALF = SCLK_DIV / 2;
    localparam int GW   = $clog2(HALF) + 1;
    // SS_n is already high for 2 clks when the gap counter first reaches 0 from this load
    localparam logic [GW-1:0] GAP_LOAD = GW'(HALF - 2);
    localparam logic [3:0]    NUM_CH_L = 4'(NUM_CHNNL);

    seq_state_t               seq_state_r;
    logic [7:0]               pend_r;
    logic [2:0]               ch_r;
    logic [GW-1:0]            gap_cnt_r;
    logic [RES_W-1:0]         buf_r [8];
    logic [RES_W-1:0]         res_r;
    logic [2:0]               res_chnnl_r;
    logic                     res_vld_r;
    logic                     cnv_cmplt_r;
    logic                     busy_r;

    logic [7:0]               mask8_s;
    logic [7:0]               pend_nxt_s;
    logic                     wrt_s;
    logic [2:0]               cmd_ch_s;
    logic                     spi_done_s;
    logic [FRAME_BITS-1:0]    rd_data_s;
    logic [RES_W-1:0]         result_s;
    logic [RES_W-1:0]         rd_res_s;
    logic                     unused_rd_data_s;

    assign res       = res_r;
    assign res_chnnl = res_chnnl_r;
    assign res_vld   = res_vld_r;
    assign cnv_cmplt = cnv_cmplt_r;
    assign busy      = busy_r;
    assign rd_res    = rd_res_s;

    // Upper response bits beyond RES_W are deliberately discarded.
    assign unused_rd_data_s = ^rd_data_s;

    // Widen the channel mask to the 8-channel index space.
    always_comb begin
        mask8_s = 8'd0;
        for (int i = 0; i < NUM_CHNNL; i++) begin
            mask8_s[i] = chnnl_mask[i];
        end
    end

    // Pending channels once the current one is served.
    always_comb begin
        pend_nxt_s = pend_r & ~(8'd1 << ch_r);
    end

    // Frame launch: straight from idle on a start, or when the gap has elapsed.
    always_comb begin
        wrt_s    = 1'b0;
        cmd_ch_s = ch_r;
        if (seq_state_r == SEQ_IDLE) begin
            cmd_ch_s = first_set(mask8_s);
            wrt_s    = strt_cnv && (mask8_s != 8'd0);
        end else if (seq_state_r == SEQ_GAP) begin
            wrt_s = (gap_cnt_r == '0);
        end else begin
            wrt_s = 1'b0;
        end
    end

    // Result formatting from the low end of the SPI response.
    always_comb begin
        if (INVERT != 0) begin
            result_s = ~rd_data_s[RES_W-1:0];
        end else begin
            result_s = rd_data_s[RES_W-1:0];
        end
    end

    // Buffer read port; indices beyond the configured channels read as zero.
    always_comb begin
        if ({1'b0, rd_chnnl} < NUM_CH_L) begin
            rd_res_s = buf_r[rd_chnnl];
        end else begin
            rd_res_s = '0;
        end
    end

    // Sweep sequencer: channel walk, result capture and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_state_r <= SEQ_IDLE;
            pend_r      <= 8'd0;
            ch_r        <= 3'd0;
            gap_cnt_r   <= '0;
            res_r       <= '0;
            res_chnnl_r <= 3'd0;
            res_vld_r   <= 1'b0;
            cnv_cmplt_r <= 1'b0;
            busy_r      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                buf_r[i] <= '0;
            end
        end else begin
            res_vld_r   <= 1'b0;
            cnv_cmplt_r <= 1'b0;
            case (seq_state_r)
                SEQ_IDLE: begin
                    if (strt_cnv) begin
                        pend_r <= mask8_s;
                        if (mask8_s == 8'd0) begin
                            cnv_cmplt_r <= 1'b1;
                        end else begin
                            ch_r        <= first_set(mask8_s);
                            busy_r      <= 1'b1;
                            seq_state_r <= SEQ_FRAME;
                        end
                    end
                end
                SEQ_FRAME: begin
                    if (spi_done_s) begin
                        buf_r[ch_r] <= result_s;
                        res_r       <= result_s;
                        res_chnnl_r <= ch_r;
                        res_vld_r   <= 1'b1;
                        pend_r      <= pend_nxt_s;
                        if (pend_nxt_s == 8'd0) begin
                            busy_r      <= 1'b0;
                            cnv_cmplt_r <= 1'b1;
                            seq_state_r <= SEQ_IDLE;
                        end else begin
                            ch_r        <= first_set(pend_nxt_s);
                            gap_cnt_r   <= GAP_LOAD;
                            seq_state_r <= SEQ_GAP;
                        end
                    end
                end
                SEQ_GAP: begin
                    if (gap_cnt_r == '0) begin
                        seq_state_r <= SEQ_FRAME;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GW'(1);
                    end
                end
                default: begin
                    seq_state_r <= SEQ_IDLE;
                end
            endcase
        end
    end

    spi_mstr_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt_s),
        .cmd     (build_cmd(cmd_ch_s)),
        .done    (spi_done_s),
        .rd_data (rd_data_s),
        .SS_n    (a2d_SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

endmodule

// File: tb/tb_a2d_rr_sampler.sv
// Directed bench for a2d_rr_sampler: a 12-bit inverting instance talking to a
// slave that answers 16'h0ABC, and a 10-bit non-inverting instance whose
// slave answers 16'hFFFF, both with SCLK_DIV=4.
module tb_a2d_rr_sampler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        strt_cnv = 1'b0;
    logic [7:0]  chnnl_mask = 8'h00;
    logic [2:0]  rd_chnnl = 3'd0;
    logic [11:0] rd_res, res;
    logic [2:0]  res_chnnl;
    logic        res_vld, cnv_cmplt, busy, ss_n, sclk, mosi;
    logic        miso = 1'b0;

    logic        strt2 = 1'b0;
    logic [7:0]  mask2 = 8'h00;
    logic [2:0]  rd_chnnl2 = 3'd0;
    logic [9:0]  rd_res2, res2;
    logic [2:0]  res_chnnl2;
    logic        res_vld2, cnv_cmplt2, busy2, ss_n2, sclk2, mosi2;
    logic        miso2;
    assign miso2 = 1'b1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    a2d_rr_sampler #(.NUM_CHNNL(8), .RES_W(12), .SCLK_DIV(4), .INVERT(1)) dut (
        .clk(clk), .rst(rst), .strt_cnv(strt_cnv), .chnnl_mask(chnnl_mask),
        .rd_chnnl(rd_chnnl), .rd_res(rd_res), .res(res), .res_chnnl(res_chnnl),
        .res_vld(res_vld), .cnv_cmplt(cnv_cmplt), .busy(busy),
        .a2d_SS_n(ss_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso)
    );

    a2d_rr_sampler #(.NUM_CHNNL(8), .RES_W(10), .SCLK_DIV(4), .INVERT(0)) dut2 (
        .clk(clk), .rst(rst), .strt_cnv(strt2), .chnnl_mask(mask2),
        .rd_chnnl(rd_chnnl2), .rd_res(rd_res2), .res(res2), .res_chnnl(res_chnnl2),
        .res_vld(res_vld2), .cnv_cmplt(cnv_cmplt2), .busy(busy2),
        .a2d_SS_n(ss_n2), .SCLK(sclk2), .MOSI(mosi2), .MISO(miso2)
    );

    // Slave model and event recorder for the first instance.
    logic [15:0] slave_word = 16'h0ABC;
    logic [11:0] vld_res_q[$];
    logic [2:0]  vld_ch_q[$];
    logic [15:0] frame_q[$];
    int          gap_q[$];
    int          n_falls = 0, n_cmplt = 0, cmplt_at = -1, rise_cnt = 0, gap_run = 0, sl_cnt = 0;
    logic        ss_prev = 1'b1, sclk_prev = 1'b1;
    logic [15:0] mosi_sh = 16'h0000;

    // Sampled on the falling clk edge, away from DUT updates.
    always @(negedge clk) begin
        if (ss_prev === 1'b1 && ss_n === 1'b0) begin
            n_falls++;
            rise_cnt = 0;
            sl_cnt = 0;
            if (gap_run > 0) gap_q.push_back(gap_run);
            gap_run = 0;
        end
        if (ss_prev === 1'b0 && ss_n === 1'b1) frame_q.push_back(mosi_sh);
        if (ss_n === 1'b0 && sclk_prev === 1'b0 && sclk === 1'b1) begin
            mosi_sh = {mosi_sh[14:0], mosi};
            rise_cnt++;
            sl_cnt++;
        end
        miso = (sl_cnt < 16) ? slave_word[15 - sl_cnt] : 1'b0;
        if (busy === 1'b1 && ss_n === 1'b1) gap_run++;
        else if (busy !== 1'b1) gap_run = 0;
        if (res_vld === 1'b1) begin
            vld_res_q.push_back(res);
            vld_ch_q.push_back(res_chnnl);
        end
        if (cnv_cmplt === 1'b1) begin
            n_cmplt++;
            cmplt_at = vld_res_q.size();
        end
        ss_prev = ss_n;
        sclk_prev = sclk;
    end

    // Frame-length measurement for the second instance.
    int   flen = -1, flen_run = 0, n_vld2 = 0;
    bit   flen_on = 1'b0;
    logic ss2_prev = 1'b1;
    always @(negedge clk) begin
        if (ss2_prev === 1'b1 && ss_n2 === 1'b0) begin
            flen_run = 0;
            flen_on = 1'b1;
        end else if (flen_on) begin
            flen_run++;
        end
        if (res_vld2 === 1'b1) begin
            n_vld2++;
            if (flen_on) flen = flen_run;
            flen_on = 1'b0;
        end
        ss2_prev = ss_n2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bounded wait: 0 sweep-complete count, 1 result count, 2 rise count in a live frame, 3 dut2 results.
    task automatic wait_ev(input string tag, input int sel, input int target, input int max_cyc);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < max_cyc && !hit; k++) begin
            @(negedge clk);
            #1;
            case (sel)
                0: hit = (n_cmplt >= target);
                1: hit = (vld_res_q.size() >= target);
                2: hit = (ss_n === 1'b0) && (rise_cnt >= target);
                3: hit = (n_vld2 >= target);
                default: hit = 1'b1;
            endcase
        end
        chk(tag, {31'd0, hit}, 32'd1);
    endtask

    task automatic clear_q();
        vld_res_q.delete();
        vld_ch_q.delete();
        frame_q.delete();
        gap_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        strt_cnv = 1'b0;
        strt2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        clear_q();
    endtask

    task automatic start(input logic [7:0] m);
        @(negedge clk);
        chnnl_mask = m;
        strt_cnv = 1'b1;
        @(posedge clk);
        #1;
        strt_cnv = 1'b0;
    endtask

    initial begin
        int c0, f0;

        // ---- reset state
        do_reset();
        chk("rst_ss_n", ss_n, 1);
        chk("rst_sclk", sclk, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_res", res, 0);
        chk("rst_res_chnnl", res_chnnl, 0);
        chk("rst_res_vld", res_vld, 0);
        chk("rst_cnv_cmplt", cnv_cmplt, 0);
        chk("rst_busy", busy, 0);
        for (int i = 0; i < 8; i++) begin
            rd_chnnl = 3'(i);
            #1;
            chk($sformatf("rst_buf%0d", i), rd_res, 0);
        end

        // ---- full sweep, inverted 12-bit results of 16'h0ABC
        start(8'hFF);
        chk("start_busy", busy, 1);
        chk("start_ss_n", ss_n, 0);
        wait_ev("sweep_ff_timeout", 0, 1, 1500);
        chk("sweep_ff_busy_end", busy, 0);
        chk("sweep_ff_nvld", vld_res_q.size(), 8);
        chk("sweep_ff_cmplt_at", cmplt_at, 8);
        chk("sweep_ff_nframes", frame_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ff_res%0d", i), (i < vld_res_q.size()) ? vld_res_q[i] : 12'hxxx, 12'h543);
            chk($sformatf("ff_ch%0d", i), (i < vld_ch_q.size()) ? vld_ch_q[i] : 3'bxxx, i);
            chk($sformatf("ff_mosi%0d", i), (i < frame_q.size()) ? frame_q[i] : 16'hxxxx, i * 2048);
            rd_chnnl = 3'(i);
            #1;
            chk($sformatf("ff_buf%0d", i), rd_res, 12'h543);
        end

        // ---- sparse mask 1010_0100 after reset
        do_reset();
        start(8'hA4);
        wait_ev("sweep_a4_timeout", 0, 2, 1000);
        chk("a4_nvld", vld_res_q.size(), 3);
        chk("a4_ch0", (vld_ch_q.size() > 0) ? vld_ch_q[0] : 3'bxxx, 2);
        chk("a4_ch1", (vld_ch_q.size() > 1) ? vld_ch_q[1] : 3'bxxx, 5);
        chk("a4_ch2", (vld_ch_q.size() > 2) ? vld_ch_q[2] : 3'bxxx, 7);
        chk("a4_mosi0", (frame_q.size() > 0) ? frame_q[0] : 16'hxxxx, 16'h1000);
        chk("a4_mosi1", (frame_q.size() > 1) ? frame_q[1] : 16'hxxxx, 16'h2800);
        chk("a4_mosi2", (frame_q.size() > 2) ? frame_q[2] : 16'hxxxx, 16'h3800);
        chk("a4_ngaps", gap_q.size(), 2);
        chk("a4_gap0", (gap_q.size() > 0) ? gap_q[0] : -1, 2);
        chk("a4_gap1", (gap_q.size() > 1) ? gap_q[1] : -1, 2);
        rd_chnnl = 3'd3;
        #1;
        chk("a4_buf3", rd_res, 0);
        rd_chnnl = 3'd5;
        #1;
        chk("a4_buf5", rd_res, 12'h543);

        // ---- empty mask: immediate completion, no frame
        f0 = n_falls;
        c0 = n_cmplt;
        start(8'h00);
        chk("m0_cmplt", cnv_cmplt, 1);
        chk("m0_busy", busy, 0);
        @(posedge clk);
        #1;
        chk("m0_cmplt_pulse", cnv_cmplt, 0);
        repeat (20) @(negedge clk);
        #1;
        chk("m0_no_frame", n_falls - f0, 0);
        chk("m0_ncmplt", n_cmplt - c0, 1);

        // ---- re-start mid-sweep is ignored
        clear_q();
        f0 = n_falls;
        c0 = n_cmplt;
        start(8'h03);
        wait_ev("restart_first_timeout", 1, 1, 200);
        chk("restart_busy", busy, 1);
        start(8'hFF);
        wait_ev("restart_cmplt_timeout", 0, c0 + 1, 300);
        repeat (150) @(negedge clk);
        #1;
        chk("restart_nvld", vld_res_q.size(), 2);
        chk("restart_nframes", n_falls - f0, 2);
        chk("restart_ncmplt", n_cmplt - c0, 1);
        chk("restart_busy_end", busy, 0);

        // ---- reset in the middle of the channel 3 frame
        do_reset();
        start(8'hFF);
        wait_ev("midrst_ch2_timeout", 1, 3, 600);
        wait_ev("midrst_bit_timeout", 2, 8, 200);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ss_n", ss_n, 1);
        chk("midrst_sclk", sclk, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_res", res, 0);
        chk("midrst_nvld", vld_res_q.size(), 3);
        @(negedge clk);
        rst = 1'b0;
        rd_chnnl = 3'd3;
        #1;
        chk("midrst_buf3", rd_res, 0);
        rd_chnnl = 3'd0;
        #1;
        chk("midrst_buf0", rd_res, 0);

        // ---- non-inverting 10-bit instance, frame length
        @(negedge clk);
        mask2 = 8'h01;
        strt2 = 1'b1;
        @(posedge clk);
        #1;
        strt2 = 1'b0;
        wait_ev("d2_timeout", 3, 1, 200);
        chk("d2_res", res2, 10'h3FF);
        chk("d2_res_chnnl", res_chnnl2, 0);
        chk("d2_frame_len", flen, 69);
        chk("d2_busy_end", busy2, 0);
        rd_chnnl2 = 3'd0;
        @(negedge clk);
        #1;
        chk("d2_buf0", rd_res2, 10'h3FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
